mult_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit for the MIPS ALU datapath. Executes

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_if.sv | 29 ++
 rtl/mdu_sign_fix.sv | 22 ++
 rtl/mult_div_unit.sv | 193 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: default datapath
// width, operation encodings and FSM state encodings.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // Operation encodings as presented on the op input
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the ALU controller and the multiply/divide
// unit. The controller is the master and the unit is the slave.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational two's-complement conditional negate. Used to take magnitudes
// of signed operands at capture and to restore result signs at the end.
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] val,
    input  logic         neg,
    output logic [N-1:0] res
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Negate when requested, otherwise pass the value straight through
    always_comb begin
        if (neg) begin
            res = (~val) + ONE;
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the MIPS ALU datapath. MULT/MULTU use a
// shift-add loop over a double-width accumulator; DIV/DIVU use a restoring
// shift-subtract loop. Signed ops run on magnitudes and fix signs at the end,
// so every op takes the same WIDTH+1 edges from capture to done.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic   clk,
    input  logic   reset_n,
    mdu_if.slave   bus
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    // Control and captured-operand state
    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic               is_div_r;
    logic               b_zero_r;
    logic               neg_main_r;
    logic               neg_rem_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH-1:0]   a_mag_r;
    logic [WIDTH-1:0]   b_mag_r;

    // Arithmetic state
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;

    // Registered outputs
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Decode and step results
    logic               op_signed_s;
    logic               op_div_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH+1:0]   shifted_s;
    logic [WIDTH+1:0]   diff_s;
    logic [WIDTH:0]     rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Classify the requested op and decide which operands need negating
    always_comb begin
        case (bus.op)
            OP_MULT:  begin op_signed_s = 1'b1; op_div_s = 1'b0; end
            OP_MULTU: begin op_signed_s = 1'b0; op_div_s = 1'b0; end
            OP_DIV:   begin op_signed_s = 1'b1; op_div_s = 1'b1; end
            OP_DIVU:  begin op_signed_s = 1'b0; op_div_s = 1'b1; end
            default:  begin op_signed_s = 1'b0; op_div_s = 1'b0; end
        endcase
        neg_a_s = op_signed_s & bus.A[WIDTH-1];
        neg_b_s = op_signed_s & bus.B[WIDTH-1];
    end

    mdu_sign_fix #(.N(WIDTH)) u_abs_a (.val(bus.A), .neg(neg_a_s), .res(a_abs_s));
    mdu_sign_fix #(.N(WIDTH)) u_abs_b (.val(bus.B), .neg(neg_b_s), .res(b_abs_s));

    // One shift-add multiply step: add multiplicand on LSB, then shift right
    always_comb begin
        if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_r};
        end else begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end

    // One restoring divide step; the extra top bit of diff_s is the borrow
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {2'b00, b_mag_r};
        if (diff_s[WIDTH+1]) begin
            rem_next_s = shifted_s[WIDTH:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_s = diff_s[WIDTH:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (.val(acc_r),              .neg(neg_main_r), .res(prod_fix_s));
    mdu_sign_fix #(.N(WIDTH))   u_fix_quo  (.val(quo_r),              .neg(neg_main_r), .res(quo_fix_s));
    mdu_sign_fix #(.N(WIDTH))   u_fix_rem  (.val(rem_r[WIDTH-1:0]),   .neg(neg_rem_r),  .res(rem_fix_s));

    // Sequencer: capture in IDLE, iterate in CALC, sign-fix and publish in FIX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            is_div_r   <= 1'b0;
            b_zero_r   <= 1'b0;
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
            a_mag_r    <= {WIDTH{1'b0}};
            b_mag_r    <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r    <= S_CALC;
                        busy_r     <= 1'b1;
                        dbz_r      <= 1'b0;
                        cnt_r      <= {CW{1'b0}};
                        is_div_r   <= op_div_s;
                        b_zero_r   <= (bus.B == {WIDTH{1'b0}});
                        neg_main_r <= op_signed_s & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_rem_r  <= neg_a_s;
                        a_raw_r    <= bus.A;
                        a_mag_r    <= a_abs_s;
                        b_mag_r    <= b_abs_s;
                        acc_r      <= {{WIDTH{1'b0}}, b_abs_s};
                        rem_r      <= {(WIDTH+1){1'b0}};
                        quo_r      <= a_abs_s;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (is_div_r) begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                    end else begin
                        acc_r <= acc_next_s;
                    end
                    if (cnt_r == LAST_STEP) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_FIX: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    if (is_div_r && b_zero_r) begin
                        hi_r  <= a_raw_r;
                        lo_r  <= {WIDTH{1'b1}};
                        dbz_r <= 1'b1;
                    end else if (is_div_r) begin
                        hi_r  <= rem_fix_s;
                        lo_r  <= quo_fix_s;
                        dbz_r <= 1'b0;
                    end else begin
                        hi_r  <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r  <= prod_fix_s[WIDTH-1:0];
                        dbz_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// ops compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV / and % truncate toward zero
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo, output logic dbz);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        dbz = 1'b0;
        hi  = 32'd0;
        lo  = 32'd0;
        if (op == OP_MULT) begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == OP_MULTU) begin
            p  = ua * ub;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
            hi  = a;
            lo  = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            lo = 32'(sq);
            hi = 32'(sr);
        end else begin
            p  = ua / ub;
            lo = p[31:0];
            p  = ua % ub;
            hi = p[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'($urandom_range(0, 20));
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    // Issue one op, optionally pulse a competing start at cycle inject_at,
    // then check latency, busy, and the result against the model.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input string tag);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dbz;
        int          n;
        logic        busy_ok;
        ref_model(op, a, b, e_hi, e_lo, e_dbz);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.op    = 2'($urandom);
        n       = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.A     = 32'd9;
                bus.B     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e_hi});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e_lo});
        check({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, e_dbz});
    endtask

    // Watch a quiet window: no further done pulse, unit stays idle
    task automatic check_quiet(input string tag);
        logic extra;
        extra = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
        end
        check(tag, {63'd0, extra}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed corners
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, "mult_m3x5");
        check("mult_m3x5_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFF1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, "div_m7_2");
        check("div_m7_2_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
        run_op(OP_DIVU, 32'd7, 32'd2, -1, "divu_7_2");
        run_op(OP_DIVU, 32'd100, 32'd0, -1, "divu_by0");
        check("divu_by0_hi_const", {32'd0, bus.hi}, 64'h0000_0000_0000_0064);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf_lo_const", {32'd0, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, -1, "div_by0");

        // start while busy (CALC and FIX) is ignored and not queued
        run_op(OP_MULTU, 32'd2, 32'd3, 5, "ign_calc");
        check("ign_calc_lo_const", {32'd0, bus.lo}, 64'd6);
        check_quiet("ign_calc_noqueue");
        run_op(OP_MULTU, 32'd2, 32'd3, 32, "ign_fix");
        check_quiet("ign_fix_noqueue");

        // Back-to-back: each run_op issues start in the previous done cycle
        run_op(OP_DIVU, 32'd9, 32'd3, -1, "b2b_0");
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, "b2b_1");
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, "b2b_2");

        // Asynchronous reset mid-operation
        run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, -1, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.A     = 32'hFFFF_FFF3;
        bus.B     = 32'h0000_0777;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(OP_MULTU, 32'd4, 32'd4, -1, "post_rst");

        // Randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), -1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
